// File: rtl/pcie_datalink_pkg.sv
// pcie_datalink_pkg: DLLP type codes, flow-control body layout and RX decoder types
package pcie_datalink_pkg;
  localparam logic [7:0] DLLP_INITFC1_P   = 8'h40;
  localparam logic [7:0] DLLP_INITFC1_NP  = 8'h50;
  localparam logic [7:0] DLLP_INITFC1_CPL = 8'h60;
  localparam logic [7:0] DLLP_INITFC2_P   = 8'hC0;
  localparam logic [7:0] DLLP_INITFC2_NP  = 8'hD0;
  localparam logic [7:0] DLLP_INITFC2_CPL = 8'hE0;
  localparam logic [7:0] DLLP_UPDATEFC_P   = 8'h80;
  localparam logic [7:0] DLLP_UPDATEFC_NP  = 8'h90;
  localparam logic [7:0] DLLP_UPDATEFC_CPL = 8'hA0;
  localparam logic [15:0] CRC_POLY = 16'h100B;
  // Packed MSB-first, so byte0 (type/VC) lands in bits [7:0]
  typedef struct packed {
    logic [7:0] data_lo;
    logic [1:0] hdr_lo;
    logic [1:0] dscale;
    logic [3:0] data_hi;
    logic [1:0] hscale;
    logic [5:0] hdr_hi;
    logic [4:0] typ;
    logic [2:0] vc;
  } dllp_fc_t;
  typedef struct packed {
    logic [7:0]  hdr;
    logic [11:0] data;
  } fc_credit_t;
  typedef enum logic [1:0] {ST_BODY, ST_CRC, ST_DROP} fc_rx_state_e;
  typedef enum logic [1:0] {FC_NONE, FC_INIT1, FC_INIT2, FC_UPD} fc_kind_e;
  // Classifies the 5-bit type field (byte0[7:3]); the VC bits are matched separately
  function automatic fc_kind_e fc_kind(input logic [4:0] typ);
    case ({typ, 3'b000})
      DLLP_INITFC1_P, DLLP_INITFC1_NP, DLLP_INITFC1_CPL:    return FC_INIT1;
      DLLP_INITFC2_P, DLLP_INITFC2_NP, DLLP_INITFC2_CPL:    return FC_INIT2;
      DLLP_UPDATEFC_P, DLLP_UPDATEFC_NP, DLLP_UPDATEFC_CPL: return FC_UPD;
      default:                                              return FC_NONE;
    endcase
  endfunction
endpackage

// File: rtl/pcie_datalink_crc.sv
// pcie_datalink_crc: DLLP CRC-16 (poly 100Bh) over a 4-byte body, byte0 first, LSB first
module pcie_datalink_crc
  import pcie_datalink_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [15:0] i_crc,
  output logic [15:0] o_crc
);
  // Bit-serial LFSR unrolled over the 32 body bits
  always_comb begin
    o_crc = i_crc;
    for (int i = 0; i < 32; i++) o_crc = {o_crc[14:0], 1'b0} ^ ((o_crc[15] ^ i_data[i]) ? CRC_POLY : 16'h0);
  end
endmodule

// File: rtl/pcie_flow_ctrl_rx.sv
// pcie_flow_ctrl_rx: DLLP RX flow-control decoder recording link-partner credit limits for one VC
module pcie_flow_ctrl_rx
  import pcie_datalink_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int         USER_WIDTH = 3,
  parameter logic [2:0] VC_ID      = 3'd0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dl_down_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic                  fc1_values_stored_o,
  output logic                  fc2_values_stored_o,
  output logic [7:0]            p_hdr_o,
  output logic [7:0]            np_hdr_o,
  output logic [7:0]            cpl_hdr_o,
  output logic [11:0]           p_data_o,
  output logic [11:0]           np_data_o,
  output logic [11:0]           cpl_data_o,
  output logic                  crc_err_o,
  output logic                  fmt_err_o
);
  fc_rx_state_e r_state;
  logic [31:0]  r_body;
  logic [15:0]  r_crc, w_crc;
  fc_credit_t   r_cred [3];
  logic [2:0]   r_got, r_hinf, r_dinf, w_got_nxt;
  logic         r_fc1, r_fc2, r_crc_err, r_fmt_err, r_ready;
  dllp_fc_t     w_b;
  fc_kind_e     w_kind;
  logic [1:0]   w_idx;
  fc_credit_t   w_new;
  logic         w_end, w_match, w_commit, w_take_init, w_take_upd, w_set_fc2;
  logic         w_unused;
  assign w_unused = ^{s_axis_tkeep, s_axis_tuser, s_axis_tdata};
  pcie_datalink_crc u_crc (
    .i_data (s_axis_tdata[31:0]),
    .i_crc  ('1),
    .o_crc  (w_crc)
  );
  // Decode the latched body and decide what the closing CRC beat commits
  always_comb begin
    w_b         = dllp_fc_t'(r_body);
    w_kind      = fc_kind(w_b.typ);
    w_idx       = w_b.typ[2:1];
    w_new       = '{hdr: {w_b.hdr_hi, w_b.hdr_lo}, data: {w_b.data_hi, w_b.data_lo}};
    w_end       = s_axis_tvalid && s_axis_tlast && r_state == ST_CRC;
    w_match     = s_axis_tdata[15:0] == ~r_crc;
    w_commit    = w_end && w_match && w_b.vc == VC_ID;
    w_take_init = w_commit && (w_kind == FC_INIT1 || w_kind == FC_INIT2) && !r_got[w_idx];
    w_take_upd  = w_commit && w_kind == FC_UPD && r_fc2;
    w_got_nxt   = r_got | (w_take_init ? 3'(1) << w_idx : 3'b0);
    w_set_fc2   = w_commit && (w_kind == FC_INIT2 || w_kind == FC_UPD) && &w_got_nxt;
  end
  // Framing FSM, credit storage and status flags; dl_down overrides any same-cycle commit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_BODY;
      r_body    <= '0;
      r_crc     <= '0;
      r_cred    <= '{default: '0};
      r_got     <= '0;
      r_hinf    <= '0;
      r_dinf    <= '0;
      r_fc1     <= 1'b0;
      r_fc2     <= 1'b0;
      r_crc_err <= 1'b0;
      r_fmt_err <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (dl_down_i) begin
        r_state   <= ST_BODY;
        r_cred    <= '{default: '0};
        r_got     <= '0;
        r_hinf    <= '0;
        r_dinf    <= '0;
        r_fc1     <= 1'b0;
        r_fc2     <= 1'b0;
        r_crc_err <= 1'b0;
        r_fmt_err <= 1'b0;
      end else begin
        r_crc_err <= w_end && !w_match;
        r_fmt_err <= s_axis_tvalid && (r_state == ST_BODY ? s_axis_tlast : r_state == ST_CRC && !s_axis_tlast);
        if (s_axis_tvalid) r_state <= s_axis_tlast ? ST_BODY : (r_state == ST_BODY ? ST_CRC : ST_DROP);
        if (s_axis_tvalid && r_state == ST_BODY) begin
          r_body <= s_axis_tdata[31:0];
          r_crc  <= w_crc;
        end
        if (w_take_init) begin
          r_cred[w_idx] <= w_new;
          r_hinf[w_idx] <= w_new.hdr == '0;
          r_dinf[w_idx] <= w_new.data == '0;
        end
        if (w_take_upd && !r_hinf[w_idx]) r_cred[w_idx].hdr <= w_new.hdr;
        if (w_take_upd && !r_dinf[w_idx]) r_cred[w_idx].data <= w_new.data;
        r_got <= w_got_nxt;
        r_fc1 <= &w_got_nxt;
        if (w_set_fc2) r_fc2 <= 1'b1;
      end
    end
  end
  assign s_axis_tready       = r_ready;
  assign fc1_values_stored_o = r_fc1;
  assign fc2_values_stored_o = r_fc2;
  assign p_hdr_o             = r_cred[0].hdr;
  assign np_hdr_o            = r_cred[1].hdr;
  assign cpl_hdr_o           = r_cred[2].hdr;
  assign p_data_o            = r_cred[0].data;
  assign np_data_o           = r_cred[1].data;
  assign cpl_data_o          = r_cred[2].data;
  assign crc_err_o           = r_crc_err;
  assign fmt_err_o           = r_fmt_err;
endmodule

// File: tb/tb_pcie_flow_ctrl_rx.sv
// tb_pcie_flow_ctrl_rx: directed and randomized DLLP stimulus against a credit-table model
module tb_pcie_flow_ctrl_rx;
  logic        clk = 0;
  logic        rst, dl_down;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast;
  logic [2:0]  tuser;
  logic        tready, fc1, fc2, crc_err, fmt_err;
  logic [7:0]  p_hdr, np_hdr, cpl_hdr;
  logic [11:0] p_data, np_data, cpl_data;
  int          n_chk = 0, n_pass = 0;
  bit          m_got [3], m_hinf [3], m_dinf [3], m_fc2;
  logic [7:0]  m_hdr [3];
  logic [11:0] m_data [3];
  logic [7:0]  codes [13] = '{8'h40, 8'h50, 8'h60, 8'hC0, 8'hD0, 8'hE0, 8'h80, 8'h90, 8'hA0, 8'h00, 8'h10, 8'h20, 8'h30};
  always #5 clk = ~clk;
  pcie_flow_ctrl_rx dut (
    .clk_i (clk), .rst_i (rst), .dl_down_i (dl_down),
    .s_axis_tdata (tdata), .s_axis_tkeep (tkeep), .s_axis_tvalid (tvalid),
    .s_axis_tlast (tlast), .s_axis_tuser (tuser), .s_axis_tready (tready),
    .fc1_values_stored_o (fc1), .fc2_values_stored_o (fc2),
    .p_hdr_o (p_hdr), .np_hdr_o (np_hdr), .cpl_hdr_o (cpl_hdr),
    .p_data_o (p_data), .np_data_o (np_data), .cpl_data_o (cpl_data),
    .crc_err_o (crc_err), .fmt_err_o (fmt_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [15:0] crc16(input logic [31:0] body);
    logic [15:0] c = 16'hFFFF;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++) begin
        bit fb = c[15] ^ body[8*b+k];
        c = c << 1;
        if (fb) c ^= 16'h100B;
      end
    return c;
  endfunction
  function automatic void m_clear();
    for (int i = 0; i < 3; i++) begin
      m_got[i] = 0; m_hinf[i] = 0; m_dinf[i] = 0; m_hdr[i] = 0; m_data[i] = 0;
    end
    m_fc2 = 0;
  endfunction
  function automatic bit m_all();
    return m_got[0] && m_got[1] && m_got[2];
  endfunction
  function automatic void model(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
    int kind, i;
    if (t[3:0] != 0) return;
    case (t[7:4])
      4'h4, 4'h5, 4'h6: begin kind = 1; i = int'(t[7:4]) - 4; end
      4'hC, 4'hD, 4'hE: begin kind = 2; i = int'(t[7:4]) - 12; end
      4'h8, 4'h9, 4'hA: begin kind = 3; i = int'(t[7:4]) - 8; end
      default: return;
    endcase
    if (kind < 3) begin
      if (!m_got[i]) begin
        m_got[i] = 1; m_hdr[i] = h; m_data[i] = d; m_hinf[i] = h == 0; m_dinf[i] = d == 0;
      end
      if (kind == 2 && m_all()) m_fc2 = 1;
    end else begin
      if (m_fc2) begin
        if (!m_hinf[i]) m_hdr[i] = h;
        if (!m_dinf[i]) m_data[i] = d;
      end
      if (m_all()) m_fc2 = 1;
    end
  endfunction
  task automatic check_all();
    check("fc1", fc1, m_all());
    check("fc2", fc2, m_fc2);
    check("p_hdr", p_hdr, m_hdr[0]);
    check("np_hdr", np_hdr, m_hdr[1]);
    check("cpl_hdr", cpl_hdr, m_hdr[2]);
    check("p_data", p_data, m_data[0]);
    check("np_data", np_data, m_data[1]);
    check("cpl_data", cpl_data, m_data[2]);
  endtask
  task automatic beat(input logic [31:0] d, input bit last);
    tdata = d; tkeep = last ? 4'h3 : 4'hF; tvalid = 1; tlast = last; tuser = 3'($urandom);
    @(posedge clk); #1;
    tvalid = 0; tlast = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d, input bit bad);
    logic [31:0] body;
    logic [15:0] c;
    body = {d[7:0], h[1:0], 2'($urandom), d[11:8], 2'($urandom), h[7:2], t};
    c = ~crc16(body);
    if (bad) c ^= 16'h1 << $urandom_range(15, 0);
    beat(body, 0);
    beat({16'($urandom), c}, 1);
    check("crc_err", crc_err, bad);
    if (!bad) void'(model(t, h, d));
    check_all();
  endtask
  task automatic link_down();
    dl_down = 1;
    idle(1);
    dl_down = 0;
    m_clear();
    check_all();
  endtask
  initial begin
    rst = 1; dl_down = 0; tvalid = 0; tlast = 0; tdata = 0; tkeep = 0; tuser = 0;
    m_clear();
    idle(3);
    check("tready_rst", tready, 0);
    check("crc_err_rst", crc_err, 0);
    check("fmt_err_rst", fmt_err, 0);
    check_all();
    rst = 0;
    idle(1);
    check("tready", tready, 1);
    send(8'h40, 8'h20, 12'h010, 0);
    send(8'h50, 8'h20, 12'h000, 0);
    check("fc1_partial", fc1, 0);
    send(8'h60, 8'h00, 12'h000, 0);
    check("fc1_set", fc1, 1);
    send(8'hC0, 8'h05, 12'h005, 0);
    check("fc2_set", fc2, 1);
    check("p_hdr_keep", p_hdr, 8'h20);
    send(8'h80, 8'h24, 12'h018, 0);
    check("p_hdr_upd", p_hdr, 8'h24);
    check("p_data_upd", p_data, 12'h018);
    send(8'hA0, 8'h10, 12'h040, 0);
    check("cpl_inf", {cpl_hdr, cpl_data}, 0);
    send(8'h40, 8'h33, 12'h044, 1);
    idle(1);
    check("crc_err_once", crc_err, 0);
    beat(32'hDEADBEEF, 1);
    check("fmt_single", fmt_err, 1);
    idle(1);
    check("fmt_once", fmt_err, 0);
    link_down();
    check("dl_fc2", fc2, 0);
    beat(32'h12345678, 0);
    beat(32'h9ABCDEF0, 0);
    check("fmt_3beat", fmt_err, 1);
    beat(32'h0BADF00D, 1);
    check("fmt_drop_end", fmt_err, 0);
    send(8'h50, 8'h11, 12'h0AB, 0);
    check("np_hdr_b2b", np_hdr, 8'h11);
    check("np_data_b2b", np_data, 12'h0AB);
    beat(32'h00000040, 0);
    link_down();
    send(8'h40, 8'h07, 12'h070, 0);
    beat(32'h00000050, 0);
    rst = 1;
    #1;
    m_clear();
    check("tready_mid_rst", tready, 0);
    check_all();
    idle(1);
    rst = 0;
    idle(1);
    check("tready_after", tready, 1);
    send(8'h60, 8'h09, 12'h090, 0);
    check("cpl_after_rst", cpl_hdr, 8'h09);
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(99);
      if (r < 4) link_down();
      else if (r < 8) begin
        beat($urandom, 1);
        check("fmt_rand", fmt_err, 1);
      end else begin
        logic [7:0]  t = codes[$urandom_range(12)];
        logic [7:0]  h = $urandom_range(3) == 0 ? 8'h0 : 8'($urandom);
        logic [11:0] d = $urandom_range(3) == 0 ? 12'h0 : 12'($urandom);
        if ($urandom_range(4) == 0) t[2:0] = 3'($urandom);
        send(t, h, d, $urandom_range(9) == 0);
      end
      idle($urandom_range(2));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
